systemx_sweep_ctrl: RTL

Self-test sequencer for the 3-input combinational block systemx. On a start pulse it drives all 8 input vectors onto systemx's A/B/C. It holds each vector for a programmable settle time and samples F into an 8-bit truth table. It then compares the table against an expected pattern and reports done/pass. It sits beside a systemx instance and replaces hand-written vector sweeps in benches and board bring-up.

---
 rtl/systemx_sweep_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/systemx_sweep_ctrl.sv
// systemx_sweep_ctrl: drives all 8 A/B/C vectors into systemx, samples F into a truth table, reports done/pass.
// Optional SYSTEMX_SWEEP_FAILIDX_EN adds fail_valid/fail_idx (first mismatching vector).
module systemx_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       sys_a,
  output logic       sys_b,
  output logic       sys_c,
  input  logic       sys_f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [2:0] vec_idx
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
  ,
  output logic       fail_valid,
  output logic [2:0] fail_idx
`endif
);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam logic [3:0] DWELL_MAX = 4'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] dwell, dwell_n;
  logic [2:0] vec, vec_n, idx_n;
  logic [7:0] tt_n, tt_cap;
  logic busy_n, done_n, pass_n;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
  logic fv_n;
  logic [2:0] fi_n;
`endif
  assign {sys_a, sys_b, sys_c} = vec;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dwell <= '0;
      vec <= '0;
      vec_idx <= '0;
      truth_table <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
      fail_valid <= 1'b0;
      fail_idx <= '0;
`endif
    end else begin
      state <= state_n;
      dwell <= dwell_n;
      vec <= vec_n;
      vec_idx <= idx_n;
      truth_table <= tt_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
      fail_valid <= fv_n;
      fail_idx <= fi_n;
`endif
    end
  end
  always_comb begin
    state_n = state;
    dwell_n = dwell;
    vec_n = vec;
    idx_n = vec_idx;
    tt_n = truth_table;
    busy_n = busy;
    done_n = done;
    pass_n = pass;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
    fv_n = fail_valid;
    fi_n = fail_idx;
`endif
    // pass must see the bit captured on the final edge, so compare the merged table
    tt_cap = truth_table;
    tt_cap[vec_idx] = sys_f;
    case (state)
      APPLY: begin
        if (abort) begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b0;
          pass_n = 1'b0;
          vec_n = '0;
          idx_n = '0;
          tt_n = '0;
          dwell_n = '0;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
          fv_n = 1'b0;
          fi_n = '0;
`endif
        end else if (dwell == DWELL_MAX) begin
          tt_n = tt_cap;
          dwell_n = '0;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
          if (!fail_valid && sys_f != EXPECTED[vec_idx]) begin
            fv_n = 1'b1;
            fi_n = vec_idx;
          end
`endif
          if (vec_idx == 3'd7) begin
            state_n = DONE;
            busy_n = 1'b0;
            done_n = 1'b1;
            pass_n = tt_cap == EXPECTED;
            vec_n = '0;
          end else begin
            idx_n = vec_idx + 3'd1;
            vec_n = vec_idx + 3'd1;
          end
        end else begin
          dwell_n = dwell + 4'd1;
        end
      end
      default: begin
        if (start && !abort) begin
          state_n = APPLY;
          busy_n = 1'b1;
          done_n = 1'b0;
          pass_n = 1'b0;
          tt_n = '0;
          idx_n = '0;
          vec_n = '0;
          dwell_n = '0;
`ifdef SYSTEMX_SWEEP_FAILIDX_EN
          fv_n = 1'b0;
          fi_n = '0;
`endif
        end
      end
    endcase
  end
endmodule
